// File: rtl/vm_pkg.sv
// Shared types for the VotingMachine readout path: candidate ids, counts and
// the sweep FSM state encoding.
package vm_pkg;

  localparam int NUM_CAND = 4;

  typedef logic [1:0] cand_id_t;
  typedef logic [7:0] count_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MODE_ON = 3'd1,
    ST_PRESS   = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_SAMPLE  = 3'd4,
    ST_EMIT    = 3'd5,
    ST_FINISH  = 3'd6
  } rdr_state_t;

endpackage

// File: rtl/vote_tally_winner.sv
// Running maximum over the candidate counts of one sweep; remembers the lowest
// id holding the maximum and whether another candidate matched it.
module vote_tally_winner
  import vm_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     clear,
  input  logic     load_en,
  input  cand_id_t id,
  input  count_t   count,
  output cand_id_t winner_id,
  output count_t   winner_count,
  output logic     tie
);

  count_t   r_best;
  cand_id_t r_winnerId;
  logic     r_tie;

  // Candidate 0 always seeds the tracker so stale state never leaks in.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_best     <= '0;
      r_winnerId <= '0;
      r_tie      <= 1'b0;
    end else if (load_en) begin
      if (id == '0 || count > r_best) begin
        r_best     <= count;
        r_winnerId <= id;
        r_tie      <= 1'b0;
      end else if (count == r_best) begin
        r_tie <= 1'b1;
      end
    end
  end

  assign winner_id    = r_winnerId;
  assign winner_count = r_best;
  assign tie          = r_tie;

endmodule

// File: rtl/vote_tally_reader.sv
// Drives a VotingMachine through display mode, presses each candidate button,
// samples the LED count and streams one tally record per candidate.
module vote_tally_reader
  import vm_pkg::*;
#(
  parameter int HOLD_CYCLES   = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] led_in,
  output logic       vm_mode,
  output logic       vm_button1,
  output logic       vm_button2,
  output logic       vm_button3,
  output logic       vm_button4,
  output logic       tally_valid,
  input  logic       tally_ready,
  output logic [1:0] tally_id,
  output logic [7:0] tally_count,
  output logic       busy,
  output logic       done,
  output logic [1:0] winner_id,
  output logic [7:0] winner_count,
  output logic       tie
);

  localparam int MAX_CYC = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
  localparam int PW = $clog2(MAX_CYC + 1);
  localparam logic [PW-1:0] HOLD_LOAD   = PW'(HOLD_CYCLES - 1);
  localparam logic [PW-1:0] SETTLE_LOAD = PW'(SETTLE_CYCLES - 1);
  localparam cand_id_t LAST_CAND = cand_id_t'(NUM_CAND - 1);

  rdr_state_t    r_state;
  cand_id_t      r_k;
  logic [PW-1:0] r_phase;
  logic          r_vmMode;
  logic [3:0]    r_buttons;
  logic          r_valid;
  cand_id_t      r_tallyId;
  count_t        r_tallyCount;
  logic          r_busy;
  logic          r_done;

  rdr_state_t    w_nextState;
  cand_id_t      w_nextK;
  logic [PW-1:0] w_nextPhase;
  logic [3:0]    w_nextButtons;
  logic          w_clearTracker;
  logic          w_loadTracker;

  // The phase counter counts down to zero and is reloaded on every phase entry.
  always_comb begin
    w_nextState = r_state;
    w_nextK     = r_k;
    w_nextPhase = r_phase;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_nextState = ST_MODE_ON;
          w_nextK     = '0;
        end
      end
      ST_MODE_ON: begin
        w_nextState = ST_PRESS;
        w_nextPhase = HOLD_LOAD;
      end
      ST_PRESS: begin
        if (r_phase == '0) begin
          w_nextState = ST_SETTLE;
          w_nextPhase = SETTLE_LOAD;
        end else begin
          w_nextPhase = r_phase - PW'(1);
        end
      end
      ST_SETTLE: begin
        if (r_phase == '0) w_nextState = ST_SAMPLE;
        else               w_nextPhase = r_phase - PW'(1);
      end
      ST_SAMPLE: w_nextState = ST_EMIT;
      ST_EMIT: begin
        if (tally_ready) begin
          if (r_k == LAST_CAND) begin
            w_nextState = ST_FINISH;
          end else begin
            w_nextState = ST_PRESS;
            w_nextK     = r_k + cand_id_t'(1);
            w_nextPhase = HOLD_LOAD;
          end
        end
      end
      ST_FINISH: w_nextState = ST_IDLE;
      default:   w_nextState = ST_IDLE;
    endcase
  end

  assign w_nextButtons  = (w_nextState == ST_PRESS) ? (4'b0001 << w_nextK) : 4'b0000;
  assign w_clearTracker = (r_state == ST_IDLE) && start;
  assign w_loadTracker  = (r_state == ST_SAMPLE);

  // Outputs are decoded from the next state so they change on the same edge as the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_k          <= '0;
      r_phase      <= '0;
      r_vmMode     <= 1'b0;
      r_buttons    <= '0;
      r_valid      <= 1'b0;
      r_tallyId    <= '0;
      r_tallyCount <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_k       <= w_nextK;
      r_phase   <= w_nextPhase;
      r_vmMode  <= (w_nextState != ST_IDLE);
      r_busy    <= (w_nextState != ST_IDLE);
      r_buttons <= w_nextButtons;
      r_valid   <= (w_nextState == ST_EMIT);
      r_done    <= (w_nextState == ST_FINISH);
      if (r_state == ST_SAMPLE) begin
        r_tallyCount <= led_in;
        r_tallyId    <= r_k;
      end
    end
  end

  vote_tally_winner u_winner (
    .clk          (clk),
    .rst          (rst),
    .clear        (w_clearTracker),
    .load_en      (w_loadTracker),
    .id           (r_k),
    .count        (led_in),
    .winner_id    (winner_id),
    .winner_count (winner_count),
    .tie          (tie)
  );

  assign vm_mode     = r_vmMode;
  assign vm_button1  = r_buttons[0];
  assign vm_button2  = r_buttons[1];
  assign vm_button3  = r_buttons[2];
  assign vm_button4  = r_buttons[3];
  assign tally_valid = r_valid;
  assign tally_id    = r_tallyId;
  assign tally_count = r_tallyCount;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_vote_tally_reader.sv
// Directed bench for vote_tally_reader: two instances (default timing and
// HOLD=1/SETTLE=1) each driving a small VotingMachine LED model.
module tb_vote_tally_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, tallyReady;
  logic [7:0] ledIn;
  logic       vmMode, vmButton1, vmButton2, vmButton3, vmButton4;
  logic       tallyValid, busy, done, tie;
  logic [1:0] tallyId, winnerId;
  logic [7:0] tallyCount, winnerCount;

  logic       startB;
  logic [7:0] ledInB;
  logic       vmModeB, b1B, b2B, b3B, b4B, validB, busyB, doneB, tieB;
  logic [1:0] idB, winnerIdB;
  logic [7:0] countB, winnerCountB;

  vote_tally_reader dutA (
    .clk(clk), .rst(rst), .start(start), .led_in(ledIn),
    .vm_mode(vmMode), .vm_button1(vmButton1), .vm_button2(vmButton2),
    .vm_button3(vmButton3), .vm_button4(vmButton4),
    .tally_valid(tallyValid), .tally_ready(tallyReady), .tally_id(tallyId),
    .tally_count(tallyCount), .busy(busy), .done(done),
    .winner_id(winnerId), .winner_count(winnerCount), .tie(tie)
  );

  vote_tally_reader #(.HOLD_CYCLES(1), .SETTLE_CYCLES(1)) dutB (
    .clk(clk), .rst(rst), .start(startB), .led_in(ledInB),
    .vm_mode(vmModeB), .vm_button1(b1B), .vm_button2(b2B),
    .vm_button3(b3B), .vm_button4(b4B),
    .tally_valid(validB), .tally_ready(1'b1), .tally_id(idB),
    .tally_count(countB), .busy(busyB), .done(doneB),
    .winner_id(winnerIdB), .winner_count(winnerCountB), .tie(tieB)
  );

  // VotingMachine display model: LED shows the count of the last pressed button.
  logic [7:0] countsA [4];
  logic [7:0] countsB [4];
  logic [1:0] lastA = 2'd0;
  logic [1:0] lastB = 2'd0;

  always @(posedge clk) begin
    if (vmButton1) lastA <= 2'd0;
    else if (vmButton2) lastA <= 2'd1;
    else if (vmButton3) lastA <= 2'd2;
    else if (vmButton4) lastA <= 2'd3;
    if (b1B) lastB <= 2'd0;
    else if (b2B) lastB <= 2'd1;
    else if (b3B) lastB <= 2'd2;
    else if (b4B) lastB <= 2'd3;
  end

  assign ledIn  = countsA[lastA];
  assign ledInB = countsB[lastB];

  int compared   = 0;
  int mismatched = 0;

  logic [9:0] recWord [8];
  int nRec, doneCycle, oneHotViol, stallViol, stallBtnViol;
  int btnHigh [4];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Runs one sweep on dutA, optionally stalling one record and re-pulsing start.
  task automatic applyStimulus(input int stallRec, input int stallLen, input bit midStart);
    int rel;
    int stalled;
    bit inStall;
    logic [3:0] btns;
    logic [9:0] heldRec;
    nRec = 0; doneCycle = -1; oneHotViol = 0; stallViol = 0; stallBtnViol = 0;
    for (int i = 0; i < 4; i++) btnHigh[i] = 0;
    stalled = 0; inStall = 1'b0; heldRec = '0;
    tallyReady = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    rel = 1;
    while (rel < 200 && doneCycle < 0) begin
      btns = {vmButton4, vmButton3, vmButton2, vmButton1};
      if ($countones(btns) > 1) oneHotViol++;
      for (int i = 0; i < 4; i++) if (btns[i]) btnHigh[i]++;
      start = midStart && (rel == 12);
      if (done) doneCycle = rel;
      tallyReady = 1'b1;
      if (inStall && !tallyValid) stallViol++;
      if (tallyValid) begin
        if (nRec == stallRec && stalled < stallLen) begin
          if (stalled == 0) heldRec = {tallyId, tallyCount};
          else if ({tallyId, tallyCount} !== heldRec) stallViol++;
          if (btns != 4'b0000) stallBtnViol++;
          tallyReady = 1'b0;
          inStall = 1'b1;
          stalled++;
        end else begin
          if (inStall && {tallyId, tallyCount} !== heldRec) stallViol++;
          inStall = 1'b0;
          if (nRec < 8) recWord[nRec] = {tallyId, tallyCount};
          nRec++;
        end
      end
      if (doneCycle < 0) begin
        @(negedge clk);
        rel++;
      end
    end
    start = 1'b0;
    tallyReady = 1'b1;
  endtask

  task automatic checkSweep(input string name, input int expDone, input logic [1:0] expId,
                            input logic [7:0] expCnt, input logic expTie);
    checkOutput({name, "_nrec"}, nRec, 4);
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("%s_rec%0d", name, k), {22'd0, recWord[k]}, {22'd0, 2'(k), countsA[k]});
    checkOutput({name, "_done_cycle"}, doneCycle, expDone);
    checkOutput({name, "_winner"}, {winnerId, winnerCount, tie}, {expId, expCnt, expTie});
    checkOutput({name, "_onehot"}, oneHotViol, 0);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("%s_hold%0d", name, i), btnHigh[i], 2);
    @(negedge clk);
    checkOutput({name, "_after_done"}, {done, vmMode, busy}, 3'b000);
  endtask

  initial begin
    int rel;
    logic [3:0] btns;
    int ohB;
    int holdB [4];
    int doneCycB;

    rst = 1'b1; start = 1'b0; tallyReady = 1'b1; startB = 1'b0;
    for (int i = 0; i < 4; i++) begin countsA[i] = '0; countsB[i] = '0; end
    repeat (2) @(negedge clk);
    checkOutput("reset_outputs",
      {vmMode, vmButton4, vmButton3, vmButton2, vmButton1, tallyValid, tallyId, tallyCount,
       busy, done, winnerId, winnerCount, tie}, 32'd0);
    rst = 1'b0;

    $display("[TB] basic sweep");
    countsA = '{8'd2, 8'd1, 8'd1, 8'd0};
    applyStimulus(-1, 0, 1'b0);
    checkSweep("basic", 34, 2'd0, 8'd2, 1'b0);

    $display("[TB] tie handling");
    countsA = '{8'd3, 8'd5, 8'd5, 8'd1};
    applyStimulus(-1, 0, 1'b0);
    checkSweep("tie", 34, 2'd1, 8'd5, 1'b1);
    countsA = '{8'd4, 8'd4, 8'd9, 8'd0};
    applyStimulus(-1, 0, 1'b0);
    checkSweep("tie_cleared", 34, 2'd2, 8'd9, 1'b0);

    $display("[TB] backpressure");
    countsA = '{8'd7, 8'd3, 8'd6, 8'd2};
    applyStimulus(1, 7, 1'b0);
    checkSweep("stall", 41, 2'd0, 8'd7, 1'b0);
    checkOutput("stall_stable", stallViol, 0);
    checkOutput("stall_no_button", stallBtnViol, 0);

    $display("[TB] mid-sweep reset");
    countsA = '{8'd1, 8'd2, 8'd3, 8'd4};
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("in_settle_c2", {vmMode, vmButton4, vmButton3, vmButton2, vmButton1, busy}, 6'b100001);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midreset_outputs",
      {vmMode, vmButton4, vmButton3, vmButton2, vmButton1, tallyValid, tallyId, tallyCount,
       busy, done, winnerId, winnerCount, tie}, 32'd0);
    applyStimulus(-1, 0, 1'b0);
    checkSweep("after_reset", 34, 2'd3, 8'd4, 1'b0);

    $display("[TB] ignored start, all-zero counts");
    countsA = '{8'd0, 8'd0, 8'd0, 8'd0};
    applyStimulus(-1, 0, 1'b1);
    checkSweep("zero", 34, 2'd0, 8'd0, 1'b1);

    $display("[TB] HOLD=1 SETTLE=1 instance");
    countsB = '{8'd5, 8'd9, 8'd2, 8'd9};
    ohB = 0; doneCycB = -1;
    for (int i = 0; i < 4; i++) holdB[i] = 0;
    @(negedge clk); startB = 1'b1;
    @(negedge clk); startB = 1'b0;
    rel = 1;
    while (rel < 200 && doneCycB < 0) begin
      btns = {b4B, b3B, b2B, b1B};
      if ($countones(btns) > 1) ohB++;
      for (int i = 0; i < 4; i++) if (btns[i]) holdB[i]++;
      if (doneB) doneCycB = rel;
      else begin
        @(negedge clk);
        rel++;
      end
    end
    checkOutput("fast_done_cycle", doneCycB, 18);
    checkOutput("fast_onehot", ohB, 0);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("fast_hold%0d", i), holdB[i], 1);
    checkOutput("fast_winner", {winnerIdB, winnerCountB, tieB}, {2'd1, 8'd9, 1'b1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vote_tally_reader.md
# vote_tally_reader

Readout controller for `VotingMachine`, driving the other side of its button/mode interface. After voting closes, it switches the machine into display mode and presses each candidate button in turn. For each candidate it samples the 8-bit `led` count and emits one tally record per candidate over a valid/ready stream. It also reports the winner, the winning count and a tie flag when the sweep completes.

## Interface
- `HOLD_CYCLES`, default 2: cycles each `vm_buttonN` is held high; must be ≥1.
- `SETTLE_CYCLES`, default 4: cycles between button release and `led` sampling; must be ≥1.
- `clk` input, 1: single clock, rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `start` input, 1: begin a readout sweep; sampled only in IDLE.
- `led_in` input, 8: `led` output of `VotingMachine`.
- `vm_mode` output, 1: drives `VotingMachine.mode`; 1 = display.
- `vm_button1`..`vm_button4` output, 1 each: drive `VotingMachine.button1..4`.
- `tally_valid` output, 1: tally record valid.
- `tally_ready` input, 1: downstream accepts the record.
- `tally_id` output, 2: candidate index, 0..3 (0 = `button1`).
- `tally_count` output, 8: sampled count.
- `busy` output, 1: high in every state except IDLE.
- `done` output, 1: one-cycle pulse at end of sweep.
- `winner_id` output, 2: winning candidate; held until next `start`.
- `winner_count` output, 8: highest count; held.
- `tie` output, 1: at least two candidates share `winner_count`; held.

## Operation
- FSM states: IDLE, MODE_ON, PRESS, SETTLE, SAMPLE, EMIT, FINISH. A 2-bit candidate index `k` selects the current candidate.
- **IDLE:** `start`=1 moves to MODE_ON, sets `k`=0 and clears the winner tracker. `start` is ignored in every other state.
- **MODE_ON:** `vm_mode`=1 for 1 cycle, then PRESS.
- **PRESS:** `vm_button(k+1)`=1 and all other buttons 0, for HOLD_CYCLES cycles; then SETTLE.
- **SETTLE:** all buttons 0, for SETTLE_CYCLES cycles; then SAMPLE.
- **SAMPLE:** register `led_in` into `tally_count`, set `tally_id`=`k` and update the tracker; then EMIT.
- **EMIT:** `tally_valid`=1, with `tally_id` and `tally_count` stable until `tally_ready`. On the handshake, go to PRESS with `k`+1, or to FINISH if `k`=3.
- **FINISH:** `done`=1 for 1 cycle; `vm_mode` returns to 0 on the next edge; then IDLE.
- `vm_mode`=1 from MODE_ON through FINISH inclusive. At most one button is high in any cycle.
- **Winner tracker:**
  - count > best: best ← count, `winner_id` ← `k`, `tie` ← 0.
  - count == best: `tie` ← 1, and the lower id is kept.
  - Best starts at 0 with `tie` cleared. When candidate 0 is sampled, the tracker loads it unconditionally.
  - All-zero counts give `winner_id`=0, `winner_count`=0, `tie`=1.
- Counts are unsigned 8-bit; no saturation or arithmetic beyond comparison.
- Phase counter width is `$clog2(max(HOLD_CYCLES,SETTLE_CYCLES)+1)`. It reloads on each phase entry.

## Timing
- **Reset values:** all outputs 0, and the FSM is in IDLE. On the first edge with `rst`=1, whatever the state, everything returns to these values: buttons and `vm_mode` drop immediately (registered) and any EMIT in progress is abandoned.
- All outputs are registered.
- **Schedule with `tally_ready` held 1 and defaults,** counting cycle 0 as the edge that samples `start`:
  - cycle 1: MODE_ON.
  - candidate `k`: PRESS in cycles 2+8k..3+8k, SETTLE in 4+8k..7+8k, SAMPLE at 8+8k, `tally_valid` at 9+8k.
  - cycle 34: `done`.
- In general, `done` comes 2 + 4·(HOLD+SETTLE+2) cycles after start, plus any EMIT stall cycles.
- `led_in` is sampled exactly SETTLE_CYCLES cycles after the button falls.

## Structure
- Package `vm_pkg` holds:
  - `NUM_CAND`=4;
  - `cand_id_t` (logic [1:0]);
  - `count_t` (logic [7:0]);
  - the `rdr_state_t` enum.
- Sub-module `vote_tally_winner` contains the best/`winner_id`/`tie` registers. Its inputs are `clk`, `rst`, `clear`, `load_en`, `id` and `count`.
- The top level contains the FSM, phase counter, button decode and stream registers.

## Test plan
- **Basic sweep:** reset, `led_in` model returns counts {2,1,1,0} per pressed button, ready=1, pulse `start` → records (0,2),(1,1),(2,1),(3,0); `done` at cycle 34; winner 0/2, `tie`=0.
- **Tie handling:** counts {3,5,5,1} → `winner_id`=1, `winner_count`=5, `tie`=1. Counts {4,4,9,0} → `winner_id`=2, `tie`=0 (tie cleared).
- **Backpressure:** ready=0 for 7 cycles on record 1 → `tally_valid`/`tally_id`/`tally_count` stable throughout; `done` at cycle 41; no button activity during the stall.
- **Mid-sweep reset:** assert `rst` in SETTLE of candidate 2 → next cycle all outputs 0 and FSM IDLE. A new `start` then produces a full 4-record sweep.
- **Ignored start and all-zero counts:** `start` pulsed while busy → ignored, still exactly 4 records. All-zero counts → winner 0/0, `tie`=1.
- **Button checker:** check that every cycle has at most one button high. Check each button is high for exactly HOLD_CYCLES cycles per sweep, including with HOLD_CYCLES=1 and SETTLE_CYCLES=1.
